// File: rtl/spi_slave_axis_rx.sv
// SPI-slave receiver: oversamples SCLK/MOSI/CS_N in the AXI clock domain,
// deserialises words in any SPI mode and streams them out of an FWFT FIFO.
module spi_slave_axis_rx #(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned FIFO_DEPTH  = 16,
   parameter int unsigned CPOL        = 0,
   parameter int unsigned CPHA        = 0,
   parameter int unsigned MSB_FIRST   = 1,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                          axi_aclk,
   input  logic                          axi_aresetn,
   input  logic                          spi_clk,
   input  logic                          spi_mosi,
   input  logic                          spi_cs_n,
   output logic [DATA_WIDTH-1:0]         axis_tdata,
   output logic                          axis_tvalid,
   input  logic                          axis_tready,
   output logic                          axis_tlast,
   input  logic                          stat_clr,
   output logic                          overflow,
   output logic                          frame_err,
   output logic [15:0]                   drop_cnt,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned BW = $clog2(DATA_WIDTH);
   localparam int unsigned EW = DATA_WIDTH + 1;
   localparam bit SAMPLE_RISE = (CPOL == CPHA);

   typedef enum logic [1:0] {
      S_WAIT_IDLE = 2'd0,
      S_IDLE      = 2'd1,
      S_SHIFT     = 2'd2
   } state_t;

   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic                   r_sclk_d;
   logic                   r_cs_d;

   state_t                 r_state;
   logic [BW-1:0]          r_bit_cnt;
   logic [DATA_WIDTH-1:0]  r_shreg;
   logic [DATA_WIDTH-1:0]  r_pend;
   logic                   r_pend_vld;

   logic [EW-1:0]          r_mem [FIFO_DEPTH];
   logic [AW-1:0]          r_wptr;
   logic [AW-1:0]          r_rptr;
   logic [LW-1:0]          r_level;

   logic                   r_overflow;
   logic                   r_frame_err;
   logic [15:0]            r_drop_cnt;

   logic                   w_sclk;
   logic                   w_mosi;
   logic                   w_cs;
   logic                   w_cs_rise;
   logic                   w_cs_fall;
   logic                   w_sample;
   logic                   w_word_done;
   logic                   w_ferr_ev;
   logic [DATA_WIDTH-1:0]  w_shift_next;
   logic                   w_push;
   logic                   w_push_last;
   logic                   w_full;
   logic                   w_pop;
   logic                   w_wr;
   logic                   w_drop;
   logic [EW-1:0]          w_head;

   // Input synchronisers plus one delay stage for edge detection
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         r_sclk_sync <= '0;
         r_mosi_sync <= '0;
         r_cs_sync   <= '0;
         r_sclk_d    <= 1'b0;
         r_cs_d      <= 1'b0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_clk};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
         r_sclk_d    <= w_sclk;
         r_cs_d      <= w_cs;
      end
   end

   assign w_sclk    = r_sclk_sync[SYNC_STAGES-1];
   assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
   assign w_cs      = r_cs_sync[SYNC_STAGES-1];
   assign w_cs_rise = w_cs & ~r_cs_d;
   assign w_cs_fall = ~w_cs & r_cs_d;
   assign w_sample  = (SAMPLE_RISE ? (w_sclk & ~r_sclk_d) : (~w_sclk & r_sclk_d)) & ~w_cs;

   assign w_shift_next = (MSB_FIRST != 0) ? {r_shreg[DATA_WIDTH-2:0], w_mosi}
                                          : {w_mosi, r_shreg[DATA_WIDTH-1:1]};

   // A CS edge outranks a coincident sample edge
   assign w_word_done = (r_state == S_SHIFT) & ~w_cs_rise & w_sample &
                        (r_bit_cnt == BW'(DATA_WIDTH - 1));
   assign w_ferr_ev   = (r_state == S_SHIFT) & w_cs_rise & (r_bit_cnt != '0);
   assign w_push      = ((r_state == S_SHIFT) & w_cs_rise & r_pend_vld) |
                        (w_word_done & r_pend_vld);
   assign w_push_last = w_cs_rise;

   // Frame state machine; the completed word waits in r_pend until the next
   // word or CS rise decides whether it is the last of the frame
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         r_state    <= S_WAIT_IDLE;
         r_bit_cnt  <= '0;
         r_shreg    <= '0;
         r_pend     <= '0;
         r_pend_vld <= 1'b0;
      end else begin
         case (r_state)
            S_WAIT_IDLE: begin
               if (w_cs) r_state <= S_IDLE;
            end
            S_IDLE: begin
               if (w_cs_fall) begin
                  r_bit_cnt  <= '0;
                  r_shreg    <= '0;
                  r_pend_vld <= 1'b0;
                  r_state    <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (w_cs_rise) begin
                  r_pend_vld <= 1'b0;
                  r_state    <= S_IDLE;
               end else if (w_sample) begin
                  r_shreg <= w_shift_next;
                  if (w_word_done) begin
                     r_pend     <= w_shift_next;
                     r_pend_vld <= 1'b1;
                     r_bit_cnt  <= '0;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + BW'(1);
                  end
               end
            end
            default: r_state <= S_WAIT_IDLE;
         endcase
      end
   end

   assign w_full = (r_level == LW'(FIFO_DEPTH));
   assign w_pop  = axis_tvalid & axis_tready;
   assign w_wr   = w_push & (~w_full | w_pop);
   assign w_drop = w_push & w_full & ~w_pop;

   always_ff @(posedge axi_aclk) begin
      if (w_wr) r_mem[r_wptr] <= {w_push_last, r_pend};
   end

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_wr)  r_wptr <= r_wptr + AW'(1);
         if (w_pop) r_rptr <= r_rptr + AW'(1);
         r_level <= r_level + LW'(w_wr) - LW'(w_pop);
      end
   end

   // Sticky status; an event coinciding with stat_clr wins
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         r_overflow  <= 1'b0;
         r_frame_err <= 1'b0;
         r_drop_cnt  <= '0;
      end else begin
         if (w_drop) begin
            r_overflow <= 1'b1;
            if (stat_clr)                   r_drop_cnt <= 16'd1;
            else if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
         end else if (stat_clr) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
         end
         if (w_ferr_ev)     r_frame_err <= 1'b1;
         else if (stat_clr) r_frame_err <= 1'b0;
      end
   end

   assign w_head      = r_mem[r_rptr];
   assign axis_tvalid = (r_level != '0);
   assign axis_tdata  = axis_tvalid ? w_head[DATA_WIDTH-1:0] : '0;
   assign axis_tlast  = axis_tvalid & w_head[DATA_WIDTH];
   assign fifo_level  = r_level;
   assign overflow    = r_overflow;
   assign frame_err   = r_frame_err;
   assign drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_spi_slave_axis_rx.sv
// Bench for spi_slave_axis_rx: four receivers (one per SPI mode) share one
// SPI bus; received beats are compared against words rebuilt from the bit list.
module tb_spi_slave_axis_rx;

   localparam int unsigned DW = 8;
   localparam int unsigned Q  = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic sclk_a = 1'b0, sclk_b = 1'b0, mosi = 1'b0, cs_n = 1'b1;
   logic stat_clr = 1'b0, tready_m = 1'b0;

   logic [DW-1:0] tdata [4];
   logic          tvalid [4];
   logic          tlast [4];
   logic          ovf [4];
   logic          ferr [4];
   logic [15:0]   dcnt [4];
   logic [2:0]    lvl0;
   logic [4:0]    lvl1, lvl2, lvl3;

   int total = 0;
   int bad = 0;
   logic       tx_bits [$];
   logic [8:0] got [4][512];
   int         gcnt [4] = '{0, 0, 0, 0};

   // Mode 0, MSB first, shallow FIFO
   spi_slave_axis_rx #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(2)) u_m0 (
      .axi_aclk(clk), .axi_aresetn(rst_n), .spi_clk(sclk_a), .spi_mosi(mosi), .spi_cs_n(cs_n),
      .axis_tdata(tdata[0]), .axis_tvalid(tvalid[0]), .axis_tready(tready_m), .axis_tlast(tlast[0]),
      .stat_clr(stat_clr), .overflow(ovf[0]), .frame_err(ferr[0]), .drop_cnt(dcnt[0]), .fifo_level(lvl0));
   spi_slave_axis_rx #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .CPOL(0), .CPHA(1), .MSB_FIRST(0), .SYNC_STAGES(2)) u_m1 (
      .axi_aclk(clk), .axi_aresetn(rst_n), .spi_clk(sclk_b), .spi_mosi(mosi), .spi_cs_n(cs_n),
      .axis_tdata(tdata[1]), .axis_tvalid(tvalid[1]), .axis_tready(1'b1), .axis_tlast(tlast[1]),
      .stat_clr(stat_clr), .overflow(ovf[1]), .frame_err(ferr[1]), .drop_cnt(dcnt[1]), .fifo_level(lvl1));
   spi_slave_axis_rx #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .CPOL(1), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(2)) u_m2 (
      .axi_aclk(clk), .axi_aresetn(rst_n), .spi_clk(~sclk_a), .spi_mosi(mosi), .spi_cs_n(cs_n),
      .axis_tdata(tdata[2]), .axis_tvalid(tvalid[2]), .axis_tready(1'b1), .axis_tlast(tlast[2]),
      .stat_clr(stat_clr), .overflow(ovf[2]), .frame_err(ferr[2]), .drop_cnt(dcnt[2]), .fifo_level(lvl2));
   spi_slave_axis_rx #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .CPOL(1), .CPHA(1), .MSB_FIRST(0), .SYNC_STAGES(2)) u_m3 (
      .axi_aclk(clk), .axi_aresetn(rst_n), .spi_clk(~sclk_b), .spi_mosi(mosi), .spi_cs_n(cs_n),
      .axis_tdata(tdata[3]), .axis_tvalid(tvalid[3]), .axis_tready(1'b1), .axis_tlast(tlast[3]),
      .stat_clr(stat_clr), .overflow(ovf[3]), .frame_err(ferr[3]), .drop_cnt(dcnt[3]), .fifo_level(lvl3));

   // Record every accepted beat as {tlast, tdata}
   always @(negedge clk) begin
      if (rst_n) begin
         if (tvalid[0] && tready_m && gcnt[0] < 512) begin
            got[0][gcnt[0]] = {tlast[0], tdata[0]};
            gcnt[0] = gcnt[0] + 1;
         end
         for (int k = 1; k < 4; k++) begin
            if (tvalid[k] && gcnt[k] < 512) begin
               got[k][gcnt[k]] = {tlast[k], tdata[k]};
               gcnt[k] = gcnt[k] + 1;
            end
         end
      end
   end

   function automatic bit msb_of(input int k);
      return (k == 0) || (k == 2);
   endfunction

   // Word w of the current bit list as seen by a receiver of the given order
   function automatic logic [7:0] model_word(input int w, input bit msb);
      logic [7:0] r = '0;
      for (int i = 0; i < 8; i++) begin
         if (msb) r[7-i] = tx_bits[w*8+i];
         else     r[i]   = tx_bits[w*8+i];
      end
      return r;
   endfunction

   task automatic load_word(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) tx_bits.push_back(v[i]);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cs_low();
      wait_cyc(1);
      cs_n = 1'b0;
      wait_cyc(2*Q);
   endtask

   // sclk_a: first edge mid-bit (CPHA=0); sclk_b: leading edge at bit start (CPHA=1)
   task automatic send_bit(input logic b);
      mosi = b; sclk_b = 1'b1;
      wait_cyc(Q); sclk_a = 1'b1;
      wait_cyc(Q); sclk_b = 1'b0;
      wait_cyc(Q); sclk_a = 1'b0;
      wait_cyc(Q);
   endtask

   task automatic cs_high();
      wait_cyc(Q);
      cs_n = 1'b1;
   endtask

   task automatic send_frame();
      cs_low();
      foreach (tx_bits[i]) send_bit(tx_bits[i]);
      cs_high();
      wait_cyc(4*Q);
   endtask

   task automatic test_reset();
      wait_cyc(3);
      for (int k = 0; k < 4; k++) begin
         total++; if (tvalid[k] !== 1'b0) begin bad++; $display("FAIL reset_tvalid[%0d] got=%0b want=0", k, tvalid[k]); end
         total++; if (tdata[k] !== 8'h00) begin bad++; $display("FAIL reset_tdata[%0d] got=%0h want=0", k, tdata[k]); end
         total++; if (tlast[k] !== 1'b0) begin bad++; $display("FAIL reset_tlast[%0d] got=%0b want=0", k, tlast[k]); end
         total++; if (ovf[k] !== 1'b0 || ferr[k] !== 1'b0) begin bad++; $display("FAIL reset_flags[%0d] got=%0b%0b want=00", k, ovf[k], ferr[k]); end
         total++; if (dcnt[k] !== 16'h0) begin bad++; $display("FAIL reset_dcnt[%0d] got=%0h want=0", k, dcnt[k]); end
      end
      total++; if (lvl0 !== 3'd0 || lvl1 !== 5'd0 || lvl2 !== 5'd0 || lvl3 !== 5'd0) begin
         bad++; $display("FAIL reset_level got=%0d/%0d/%0d/%0d want=0", lvl0, lvl1, lvl2, lvl3);
      end
      rst_n = 1'b1;
      wait_cyc(10);
   endtask

   task automatic test_basic_frame();
      int base [4];
      int n;
      tready_m = 1'b1;
      tx_bits.delete();
      load_word(8'hA5); load_word(8'h3C);
      for (int k = 0; k < 4; k++) base[k] = gcnt[k];
      send_frame();
      wait_cyc(20);
      n = tx_bits.size() / 8;
      total++; if (got[0][base[0]] !== 9'h0A5 || got[0][base[0]+1] !== 9'h13C) begin
         bad++; $display("FAIL basic_beats got=%0h,%0h want=0a5,13c", got[0][base[0]], got[0][base[0]+1]);
      end
      for (int k = 0; k < 4; k++) begin
         total++; if (gcnt[k] - base[k] != n) begin bad++; $display("FAIL basic_count[%0d] got=%0d want=%0d", k, gcnt[k]-base[k], n); end
         for (int j = 0; j < n; j++) begin
            logic [8:0] e = {(j == n-1), model_word(j, msb_of(k))};
            total++; if (got[k][base[k]+j] !== e) begin bad++; $display("FAIL basic_beat[%0d][%0d] got=%0h want=%0h", k, j, got[k][base[k]+j], e); end
         end
         total++; if (ovf[k] !== 1'b0 || ferr[k] !== 1'b0) begin bad++; $display("FAIL basic_flags[%0d] got=%0b%0b want=00", k, ovf[k], ferr[k]); end
      end
   endtask

   task automatic test_modes();
      int base [4];
      logic [8:0] want [4] = '{9'h180, 9'h101, 9'h180, 9'h101};
      tready_m = 1'b1;
      tx_bits = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      for (int k = 0; k < 4; k++) base[k] = gcnt[k];
      send_frame();
      wait_cyc(20);
      for (int k = 0; k < 4; k++) begin
         total++; if (gcnt[k] - base[k] != 1) begin bad++; $display("FAIL modes_count[%0d] got=%0d want=1", k, gcnt[k]-base[k]); end
         total++; if (got[k][base[k]] !== want[k]) begin bad++; $display("FAIL modes_beat[%0d] got=%0h want=%0h", k, got[k][base[k]], want[k]); end
      end
   endtask

   task automatic test_random_frames();
      int base [4];
      int n;
      tready_m = 1'b1;
      repeat (4) begin
         tx_bits.delete();
         n = $urandom_range(1, 3);
         for (int w = 0; w < n; w++) load_word(8'($urandom));
         for (int k = 0; k < 4; k++) base[k] = gcnt[k];
         send_frame();
         wait_cyc(20);
         for (int k = 0; k < 4; k++) begin
            total++; if (gcnt[k] - base[k] != n) begin bad++; $display("FAIL rand_count[%0d] got=%0d want=%0d", k, gcnt[k]-base[k], n); end
            for (int j = 0; j < n; j++) begin
               logic [8:0] e = {(j == n-1), model_word(j, msb_of(k))};
               total++; if (got[k][base[k]+j] !== e) begin bad++; $display("FAIL rand_beat[%0d][%0d] got=%0h want=%0h", k, j, got[k][base[k]+j], e); end
            end
         end
      end
   endtask

   task automatic test_partial_word();
      int base [4];
      tready_m = 1'b1;
      tx_bits.delete();
      load_word(8'h55);
      repeat (3) tx_bits.push_back(1'($urandom));
      for (int k = 0; k < 4; k++) base[k] = gcnt[k];
      send_frame();
      wait_cyc(20);
      total++; if (got[0][base[0]] !== 9'h155) begin bad++; $display("FAIL partial_beat got=%0h want=155", got[0][base[0]]); end
      for (int k = 0; k < 4; k++) begin
         logic [8:0] e = {1'b1, model_word(0, msb_of(k))};
         total++; if (gcnt[k] - base[k] != 1) begin bad++; $display("FAIL partial_count[%0d] got=%0d want=1", k, gcnt[k]-base[k]); end
         total++; if (got[k][base[k]] !== e) begin bad++; $display("FAIL partial_model[%0d] got=%0h want=%0h", k, got[k][base[k]], e); end
         total++; if (ferr[k] !== 1'b1) begin bad++; $display("FAIL partial_ferr[%0d] got=%0b want=1", k, ferr[k]); end
      end
      stat_clr = 1'b1;
      wait_cyc(1);
      stat_clr = 1'b0;
      wait_cyc(1);
      for (int k = 0; k < 4; k++) begin
         total++; if (ferr[k] !== 1'b0) begin bad++; $display("FAIL partial_clr[%0d] got=%0b want=0", k, ferr[k]); end
      end
   endtask

   task automatic test_overflow();
      int base;
      logic [7:0] words [6];
      tready_m = 1'b0;
      tx_bits.delete();
      for (int w = 0; w < 6; w++) begin words[w] = 8'($urandom); load_word(words[w]); end
      send_frame();
      wait_cyc(10);
      total++; if (lvl0 !== 3'd4) begin bad++; $display("FAIL ovf_level got=%0d want=4", lvl0); end
      total++; if (ovf[0] !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b want=1", ovf[0]); end
      total++; if (dcnt[0] !== 16'd2) begin bad++; $display("FAIL ovf_dcnt got=%0d want=2", dcnt[0]); end
      base = gcnt[0];
      tready_m = 1'b1;
      wait_cyc(10);
      total++; if (gcnt[0] - base != 4) begin bad++; $display("FAIL ovf_drain_count got=%0d want=4", gcnt[0]-base); end
      for (int j = 0; j < 4; j++) begin
         total++; if (got[0][base+j] !== {1'b0, words[j]}) begin bad++; $display("FAIL ovf_beat[%0d] got=%0h want=%0h", j, got[0][base+j], {1'b0, words[j]}); end
      end
      stat_clr = 1'b1;
      wait_cyc(1);
      stat_clr = 1'b0;
      wait_cyc(1);
      total++; if (ovf[0] !== 1'b0 || dcnt[0] !== 16'd0) begin bad++; $display("FAIL ovf_clr got=%0b/%0d want=0/0", ovf[0], dcnt[0]); end
   endtask

   task automatic test_collision();
      int base;
      logic [8:0] want [5];
      tready_m = 1'b0;
      tx_bits.delete();
      for (int w = 0; w < 4; w++) begin
         logic [7:0] v = 8'($urandom);
         load_word(v);
         want[w] = {(w == 3), v};
      end
      send_frame();
      wait_cyc(5);
      total++; if (lvl0 !== 3'd4) begin bad++; $display("FAIL coll_fill got=%0d want=4", lvl0); end
      tx_bits.delete();
      want[4] = {1'b1, 8'($urandom)};
      load_word(want[4][7:0]);
      base = gcnt[0];
      cs_low();
      foreach (tx_bits[i]) send_bit(tx_bits[i]);
      cs_high();
      // Pop exactly in the cycle the last word is pushed
      wait_cyc(2);
      tready_m = 1'b1;
      wait_cyc(1);
      tready_m = 1'b0;
      wait_cyc(3);
      total++; if (lvl0 !== 3'd4) begin bad++; $display("FAIL coll_level got=%0d want=4", lvl0); end
      total++; if (dcnt[0] !== 16'd0 || ovf[0] !== 1'b0) begin bad++; $display("FAIL coll_drop got=%0d/%0b want=0/0", dcnt[0], ovf[0]); end
      total++; if (gcnt[0] - base != 1) begin bad++; $display("FAIL coll_pop got=%0d want=1", gcnt[0]-base); end
      tready_m = 1'b1;
      wait_cyc(10);
      total++; if (gcnt[0] - base != 5) begin bad++; $display("FAIL coll_count got=%0d want=5", gcnt[0]-base); end
      for (int j = 0; j < 5; j++) begin
         total++; if (got[0][base+j] !== want[j]) begin bad++; $display("FAIL coll_beat[%0d] got=%0h want=%0h", j, got[0][base+j], want[j]); end
      end
   endtask

   task automatic test_reset_midframe();
      int base [4];
      tready_m = 1'b0;
      tx_bits.delete();
      load_word(8'($urandom));
      send_frame();
      wait_cyc(5);
      total++; if (tvalid[0] !== 1'b1) begin bad++; $display("FAIL rstmid_preload got=%0b want=1", tvalid[0]); end
      tx_bits.delete();
      load_word(8'($urandom));
      cs_low();
      for (int i = 0; i < 4; i++) send_bit(tx_bits[i]);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      total++; if (tvalid[0] !== 1'b0 || tlast[0] !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%0b%0b want=00", tvalid[0], tlast[0]); end
      total++; if (tdata[0] !== 8'h00) begin bad++; $display("FAIL rstmid_data got=%0h want=0", tdata[0]); end
      total++; if (lvl0 !== 3'd0) begin bad++; $display("FAIL rstmid_level got=%0d want=0", lvl0); end
      wait_cyc(2);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) base[k] = gcnt[k];
      for (int i = 4; i < 8; i++) send_bit(tx_bits[i]);
      cs_high();
      tready_m = 1'b1;
      wait_cyc(20);
      for (int k = 0; k < 4; k++) begin
         total++; if (gcnt[k] - base[k] != 0) begin bad++; $display("FAIL rstmid_ignored[%0d] got=%0d want=0", k, gcnt[k]-base[k]); end
      end
      tx_bits.delete();
      load_word(8'($urandom));
      for (int k = 0; k < 4; k++) base[k] = gcnt[k];
      send_frame();
      wait_cyc(20);
      for (int k = 0; k < 4; k++) begin
         logic [8:0] e = {1'b1, model_word(0, msb_of(k))};
         total++; if (gcnt[k] - base[k] != 1) begin bad++; $display("FAIL rstmid_next_count[%0d] got=%0d want=1", k, gcnt[k]-base[k]); end
         total++; if (got[k][base[k]] !== e) begin bad++; $display("FAIL rstmid_next_beat[%0d] got=%0h want=%0h", k, got[k][base[k]], e); end
      end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_modes();
      test_random_frames();
      test_partial_word();
      test_overflow();
      test_collision();
      test_reset_midframe();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
